alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  Operand/issue stage directly upstream of the 8-bit ALU (opcode 00 AND, 01 NOT A, 10 XOR, 11 OR).
//  Holds a small register file and accepts one instruction at a time over a valid/ready handshake.
//  Drives ALU A/B/opcode from registered operands, captures Y and writes it back to the register file.
// PARAMETERS
//  DATA_W  8  operand/result width; must match the ALU
//  NREGS   4  register-file depth; REG_AW = $clog2(NREGS) = 2
//  OP_W    2  ALU opcode width
// PORTS
//  clk          in   1       single clock; all state on rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  instr_valid  in   1       instruction offered
//  instr_ready  out  1       stage can accept (high iff state==IDLE)
//  instr_op     in   OP_W    ALU opcode
//  instr_rd     in   REG_AW  destination register
//  instr_rs1    in   REG_AW  source for A
//  instr_rs2    in   REG_AW  source for B (ignored by the ALU for NOT, still read)
//  ld_valid     in   1       direct register load strobe (any state)
//  ld_addr      in   REG_AW  load target
//  ld_data      in   DATA_W  load value
//  alu_a        out  DATA_W  to ALU A
//  alu_b        out  DATA_W  to ALU B
//  alu_opcode   out  OP_W    to ALU opcode
//  alu_y        in   DATA_W  from ALU Y (combinational ALU)
//  wb_valid     out  1       one-cycle pulse: writeback occurring
//  wb_rd        out  REG_AW  writeback register
//  wb_data      out  DATA_W  writeback value
//  dbg_addr     in   REG_AW  debug read address
//  dbg_data     out  DATA_W  regfile[dbg_addr], combinational
//  zero_flag    out  1       only with ALU_ZERO_FLAG_EN
// BEHAVIOUR
//  Reset (async assert, sync deassert by the caller): state=IDLE; all regs, alu_a/b/opcode, wb_* and zero_flag = 0.
//  instr_ready is high during reset (state IDLE).
//  FSM: IDLE -(instr_valid&&instr_ready)-> EXEC -> WB -> IDLE; no other transitions.
//  IDLE accept edge: alu_a<=rf[rs1], alu_b<=rf[rs2], alu_opcode<=op, rd latched.
//  EXEC: ALU settles; on the edge, result<=alu_y.
//  WB: wb_valid=1, wb_rd=rd, wb_data=result; rf[rd]<=result on the exiting edge.
//  Latency: wb_valid is high in the 2nd cycle after the accept edge. Throughput: 1 instruction per 3 cycles.
//  alu_a/b/opcode hold their values until the next accept. wb_data holds result; wb_valid is 0 outside WB.
//  Back-pressure: instr_valid outside IDLE is ignored and the instruction is not consumed. The source holds its fields.
//  Load vs WB to same register in the same cycle: WB wins. Different registers: both write.
//  Load and accept in the same cycle reading the same register: the operand gets the OLD value (no bypass).
//  Back-to-back dependency is safe: the next accept cannot happen before the WB write has landed.
//  Widths: all datapath is DATA_W; no carry, no extension. NOT passes rs2 value unused.
//  Reset mid-EXEC/WB: instruction abandoned, no write, no wb_valid pulse.
// CONFIGURATION
//  `ALU_ZERO_FLAG_EN defined: zero_flag port exists, reset 0, updated on the WB exit edge to (result==0), held otherwise.
//  Not defined: the port and register are absent; all other behaviour is identical.
// STRUCTURE
//  alu_pkg: OP_AND=2'b00, OP_NOT=2'b01, OP_XOR=2'b10, OP_OR=2'b11; typedef enum {IDLE,EXEC,WB} issue_state_t;
//   DATA_W/OP_W defaults.
//  Sub-module alu_regfile: NREGS x DATA_W, 2 comb read ports + dbg port, 2 write ports with fixed WB>load priority,
//   async-reset to 0.
//  Top: FSM, operand/opcode regs, result reg, optional flag; instantiates alu_regfile; ALU itself instantiated by parent.
// TESTING (bench instantiates alu_issue_stage + ALU)
//  1 Load R1=0xCC, R2=0xAA; issue AND rd=3 rs1=1 rs2=2 -> wb_valid 2 cycles after accept, wb_data=0x88, dbg R3=0x88.
//  2 Same operands: NOT rd=0 -> 0x33; XOR rd=0 -> 0x66; OR rd=0 -> 0xEE.
//    Each instruction is accepted only when instr_ready=1.
//  3 Hold instr_valid high continuously: accepts spaced exactly 3 cycles apart. instr_ready=0 in EXEC/WB.
//    Exactly one wb_valid pulse per instruction.
//  4 During WB of rd=3, ld_valid to R3=0x55 -> R3=result. Same cycle, load to R0=0x11 -> R0=0x11.
//  5 Assert rst_n=0 in EXEC -> all outputs 0 immediately, no wb pulse, regfile all 0, instr_ready=1.
//  6 With ALU_ZERO_FLAG_EN: XOR rd=2 rs1=1 rs2=1 (R1=0xCC) -> wb_data=0x00, zero_flag=1.
//    Then OR -> zero_flag=0. Rebuild without the macro: cases 1-5 pass unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU issue stage, its register file and its interface.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int NREGS  = 4;
  localparam int REG_AW = $clog2(NREGS);
  localparam int OP_W   = 2;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 2'b00,
    OP_NOT = 2'b01,
    OP_XOR = 2'b10,
    OP_OR  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } issue_state_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Bundle between the issue stage and its environment (instruction source, loader, external ALU, debug).
// zero_flag exists only when ALU_ZERO_FLAG_EN is defined.
interface alu_issue_stage_if;
  import alu_pkg::*;

  logic      instr_valid;
  logic      instr_ready;
  alu_op_t   instr_op;
  reg_addr_t instr_rd;
  reg_addr_t instr_rs1;
  reg_addr_t instr_rs2;

  logic      ld_valid;
  reg_addr_t ld_addr;
  data_t     ld_data;

  data_t     alu_a;
  data_t     alu_b;
  alu_op_t   alu_opcode;
  data_t     alu_y;

  logic      wb_valid;
  reg_addr_t wb_rd;
  data_t     wb_data;

  reg_addr_t dbg_addr;
  data_t     dbg_data;

`ifdef ALU_ZERO_FLAG_EN
  logic      zero_flag;
`endif

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
    output ld_valid, ld_addr, ld_data,
    output alu_y, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_opcode,
    input  wb_valid, wb_rd, wb_data, dbg_data
`ifdef ALU_ZERO_FLAG_EN
    , input zero_flag
`endif
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
    input  ld_valid, ld_addr, ld_data,
    input  alu_y, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_opcode,
    output wb_valid, wb_rd, wb_data, dbg_data
`ifdef ALU_ZERO_FLAG_EN
    , output zero_flag
`endif
  );

endinterface

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file: two combinational operand reads plus a debug read, no bypass.
// Two write ports per cycle; writeback overrides a load aimed at the same register.
module alu_regfile
  import alu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  reg_addr_t i_ra1,
  output data_t     o_rd1,
  input  reg_addr_t i_ra2,
  output data_t     o_rd2,
  input  reg_addr_t i_dbg_addr,
  output data_t     o_dbg_data,
  input  logic      i_wb_en,
  input  reg_addr_t i_wb_addr,
  input  data_t     i_wb_data,
  input  logic      i_ld_en,
  input  reg_addr_t i_ld_addr,
  input  data_t     i_ld_data
);

  data_t r_mem [NREGS];

  // The later non-blocking write wins, which gives writeback priority over a same-address load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_ld_en) begin
        r_mem[i_ld_addr] <= i_ld_data;
      end
      if (i_wb_en) begin
        r_mem[i_wb_addr] <= i_wb_data;
      end
    end
  end

  assign o_rd1      = r_mem[i_ra1];
  assign o_rd2      = r_mem[i_ra2];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand/issue stage for an external 8-bit ALU: IDLE->EXEC->WB, wb_valid two cycles after accept, one instruction per 3 cycles.
// instr_ready is high only in IDLE, so offers in EXEC/WB stay pending; ALU_ZERO_FLAG_EN adds a registered zero flag.
module alu_issue_stage
  import alu_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  alu_issue_stage_if.slave  bus
);

  issue_state_t r_state;
  issue_state_t w_state_nxt;

  data_t     r_alu_a;
  data_t     r_alu_b;
  alu_op_t   r_alu_op;
  reg_addr_t r_rd;
  data_t     r_result;

  logic  w_accept;
  logic  w_wb;
  data_t w_rs1_data;
  data_t w_rs2_data;

  assign w_accept = bus.instr_valid && (r_state == IDLE);
  assign w_wb     = (r_state == WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = WB;
      WB:      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operands are sampled from the pre-edge register file, so a same-cycle load is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= OP_AND;
      r_rd     <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a  <= w_rs1_data;
        r_alu_b  <= w_rs2_data;
        r_alu_op <= bus.instr_op;
        r_rd     <= bus.instr_rd;
      end
      if (r_state == EXEC) begin
        r_result <= bus.alu_y;
      end
    end
  end

  alu_regfile u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ra1      (bus.instr_rs1),
    .o_rd1      (w_rs1_data),
    .i_ra2      (bus.instr_rs2),
    .o_rd2      (w_rs2_data),
    .i_dbg_addr (bus.dbg_addr),
    .o_dbg_data (bus.dbg_data),
    .i_wb_en    (w_wb),
    .i_wb_addr  (r_rd),
    .i_wb_data  (r_result),
    .i_ld_en    (bus.ld_valid),
    .i_ld_addr  (bus.ld_addr),
    .i_ld_data  (bus.ld_data)
  );

  assign bus.instr_ready = (r_state == IDLE);
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_opcode  = r_alu_op;
  assign bus.wb_valid    = w_wb;
  assign bus.wb_rd       = r_rd;
  assign bus.wb_data     = r_result;

`ifdef ALU_ZERO_FLAG_EN
  logic r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
    end else if (w_wb) begin
      r_zero <= (r_result == '0);
    end
  end

  assign bus.zero_flag = r_zero;
`endif

endmodule
